// File: rtl/id_exe_pipe_if.sv
// Decode-to-execute bus of the ID/EX pipeline register.
// Decode drives the id_* side. The pipeline register drives the registered exe_* side.
interface id_exe_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 5
);
    logic [DATA_W-1:0]  id_pc_i;
    logic [ADDR_W-1:0]  id_rs1_i;
    logic [ADDR_W-1:0]  id_rs2_i;
    logic               id_rs1_used_i;
    logic               id_rs2_used_i;
    logic [ADDR_W-1:0]  id_rd_i;
    logic               id_wreg_i;
    logic               id_mem_rd_i;
    logic               id_mem_wr_i;
    logic [ALUOP_W-1:0] id_aluop_i;
    logic [DATA_W-1:0]  id_op1_i;
    logic [DATA_W-1:0]  id_op2_i;
    logic [DATA_W-1:0]  id_imm_i;
    logic               id_valid_i;

    logic [DATA_W-1:0]  exe_pc_o;
    logic [ADDR_W-1:0]  exe_rs1_o;
    logic [ADDR_W-1:0]  exe_rs2_o;
    logic [ADDR_W-1:0]  exe_rd_o;
    logic               exe_wreg_o;
    logic               exe_mem_rd_o;
    logic               exe_mem_wr_o;
    logic [ALUOP_W-1:0] exe_aluop_o;
    logic [DATA_W-1:0]  exe_op1_o;
    logic [DATA_W-1:0]  exe_op2_o;
    logic [DATA_W-1:0]  exe_imm_o;
    logic               exe_valid_o;

    modport master (
        output id_pc_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_rd_i,
               id_wreg_i, id_mem_rd_i, id_mem_wr_i, id_aluop_i, id_op1_i, id_op2_i,
               id_imm_i, id_valid_i,
        input  exe_pc_o, exe_rs1_o, exe_rs2_o, exe_rd_o, exe_wreg_o, exe_mem_rd_o,
               exe_mem_wr_o, exe_aluop_o, exe_op1_o, exe_op2_o, exe_imm_o, exe_valid_o
    );

    modport slave (
        input  id_pc_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_rd_i,
               id_wreg_i, id_mem_rd_i, id_mem_wr_i, id_aluop_i, id_op1_i, id_op2_i,
               id_imm_i, id_valid_i,
        output exe_pc_o, exe_rs1_o, exe_rs2_o, exe_rd_o, exe_wreg_o, exe_mem_rd_o,
               exe_mem_wr_o, exe_aluop_o, exe_op1_o, exe_op2_o, exe_imm_o, exe_valid_o
    );
endinterface

// File: rtl/id_exe_pipe.sv
// ID/EX pipeline register with hold, flush, load-use bubble insertion and a saturating bubble counter.
// Define LOAD_USE_DETECT_EN to enable hardware load-use detection. Without it, only flush bubbles are counted.
module id_exe_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    id_exe_pipe_if.slave     bus,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             lu_stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic {RUN, LU_WAIT} state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [ADDR_W-1:0]  rs1;
        logic [ADDR_W-1:0]  rs2;
        logic [ADDR_W-1:0]  rd;
        logic               wreg;
        logic               mem_rd;
        logic               mem_wr;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  op1;
        logic [DATA_W-1:0]  op2;
        logic [DATA_W-1:0]  imm;
        logic               valid;
    } exe_t;

    state_e            state_q, state_d;
    exe_t              exe_q, exe_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;
    logic              count_bubble;

`ifdef LOAD_USE_DETECT_EN
    // A bubble is never a load, so gating on RUN only makes the LU_WAIT guarantee explicit.
    assign hazard = (state_q == RUN) & exe_q.valid & exe_q.mem_rd & (exe_q.rd != '0)
                  & ((bus.id_rs1_used_i & (bus.id_rs1_i == exe_q.rd))
                   | (bus.id_rs2_used_i & (bus.id_rs2_i == exe_q.rd)))
                  & bus.id_valid_i;
`else
    logic unused_rs_used;
    assign unused_rs_used = bus.id_rs1_used_i ^ bus.id_rs2_used_i;
    assign hazard         = 1'b0;
`endif

    assign lu_stall_o = hazard & ~flush_i & ~hold_i;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        exe_d        = exe_q;
        state_d      = state_q;
        count_bubble = 1'b0;
        cnt_d        = cnt_q;

        if (flush_i) begin
            exe_d        = '0;
            state_d      = RUN;
            count_bubble = 1'b1;
        end else if (hold_i) begin
            exe_d   = exe_q;
            state_d = state_q;
        end else if (hazard) begin
            exe_d        = '0;
            state_d      = LU_WAIT;
            count_bubble = 1'b1;
        end else begin
            state_d = RUN;
            if (bus.id_valid_i) begin
                exe_d.pc     = bus.id_pc_i;
                exe_d.rs1    = bus.id_rs1_i;
                exe_d.rs2    = bus.id_rs2_i;
                exe_d.rd     = bus.id_rd_i;
                exe_d.wreg   = bus.id_wreg_i;
                exe_d.mem_rd = bus.id_mem_rd_i;
                exe_d.mem_wr = bus.id_mem_wr_i;
                exe_d.aluop  = bus.id_aluop_i;
                exe_d.op1    = bus.id_op1_i;
                exe_d.op2    = bus.id_op2_i;
                exe_d.imm    = bus.id_imm_i;
                exe_d.valid  = 1'b1;
            end else begin
                exe_d = '0;
            end
        end

        if (count_bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exe_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
        end else begin
            exe_q   <= exe_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign bus.exe_pc_o     = exe_q.pc;
    assign bus.exe_rs1_o    = exe_q.rs1;
    assign bus.exe_rs2_o    = exe_q.rs2;
    assign bus.exe_rd_o     = exe_q.rd;
    assign bus.exe_wreg_o   = exe_q.wreg;
    assign bus.exe_mem_rd_o = exe_q.mem_rd;
    assign bus.exe_mem_wr_o = exe_q.mem_wr;
    assign bus.exe_aluop_o  = exe_q.aluop;
    assign bus.exe_op1_o    = exe_q.op1;
    assign bus.exe_op2_o    = exe_q.op2;
    assign bus.exe_imm_o    = exe_q.imm;
    assign bus.exe_valid_o  = exe_q.valid;
    assign bubble_cnt_o     = cnt_q;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Directed, table-driven bench for id_exe_pipe with hand sequences for load-use, hold/flush and saturation.
module tb_id_exe_pipe;

`ifdef LOAD_USE_DETECT_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       hold_i;
    logic       flush_i;
    logic       lu_stall_o;
    logic [3:0] bubble_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    id_exe_pipe_if #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(5)) bus ();

    id_exe_pipe #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(5), .CNT_W(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .lu_stall_o   (lu_stall_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        hold, flush, valid;
        logic [4:0]  rd;
        logic        wreg, mem_rd, mem_wr;
        logic [31:0] op1;
        logic [4:0]  exp_rd;
        logic        exp_wreg, exp_mem_rd, exp_mem_wr;
        logic [31:0] exp_op1;
        logic        exp_valid;
        logic [3:0]  exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Secondary fields are derived from op1/rd so each vector only has to spell out the key ones.
    task automatic set_id(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1_used,
                          input logic [4:0] rs2, input logic rs2_used, input logic wreg,
                          input logic mem_rd, input logic mem_wr, input logic valid,
                          input logic [31:0] op1);
        bus.id_rd_i       = rd;
        bus.id_rs1_i      = rs1;
        bus.id_rs1_used_i = rs1_used;
        bus.id_rs2_i      = rs2;
        bus.id_rs2_used_i = rs2_used;
        bus.id_wreg_i     = wreg;
        bus.id_mem_rd_i   = mem_rd;
        bus.id_mem_wr_i   = mem_wr;
        bus.id_valid_i    = valid;
        bus.id_op1_i      = op1;
        bus.id_op2_i      = ~op1;
        bus.id_imm_i      = {op1[15:0], op1[31:16]};
        bus.id_pc_i       = op1 ^ 32'h0000_1000;
        bus.id_aluop_i    = rd ^ 5'h15;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        // Reset with every input driven nonzero, including hold and flush.
        rst_i   = 1'b1;
        hold_i  = 1'b1;
        flush_i = 1'b1;
        set_id(5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        check("rst_rd",     32'(bus.exe_rd_o), 32'd0);
        check("rst_wreg",   32'(bus.exe_wreg_o), 32'd0);
        check("rst_mem",    32'({bus.exe_mem_rd_o, bus.exe_mem_wr_o}), 32'd0);
        check("rst_valid",  32'(bus.exe_valid_o), 32'd0);
        check("rst_data",   bus.exe_op1_o | bus.exe_op2_o | bus.exe_imm_o | bus.exe_pc_o, 32'd0);
        check("rst_regs",   32'({bus.exe_rs1_o, bus.exe_rs2_o, bus.exe_aluop_o}), 32'd0);
        check("rst_cnt",    32'(bubble_cnt_o), 32'd0);
        check("rst_stall",  32'(lu_stall_o), 32'd0);
        rst_i = 1'b0;

        //            h  f  v  rd     w  mr mw op1            exp_rd w  mr mw exp_op1        v  cnt
        vecs[0]  = '{1'b0,1'b0,1'b1,5'd5, 1'b1,1'b0,1'b0,32'h0000_1234, 5'd5, 1'b1,1'b0,1'b0,32'h0000_1234,1'b1,4'd0};
        vecs[1]  = '{1'b0,1'b0,1'b1,5'd9, 1'b1,1'b0,1'b0,32'hAAAA_5555, 5'd9, 1'b1,1'b0,1'b0,32'hAAAA_5555,1'b1,4'd0};
        vecs[2]  = '{1'b1,1'b0,1'b1,5'd3, 1'b1,1'b0,1'b1,32'h0000_0001, 5'd9, 1'b1,1'b0,1'b0,32'hAAAA_5555,1'b1,4'd0};
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = '{1'b0,1'b0,1'b0,5'd4, 1'b1,1'b1,1'b0,32'h0000_0077, 5'd0, 1'b0,1'b0,1'b0,32'h0000_0000,1'b0,4'd0};
        vecs[6]  = '{1'b0,1'b0,1'b1,5'd12,1'b0,1'b0,1'b1,32'h0000_CAFE, 5'd12,1'b0,1'b0,1'b1,32'h0000_CAFE,1'b1,4'd0};
        vecs[7]  = '{1'b0,1'b1,1'b1,5'd6, 1'b1,1'b0,1'b0,32'h0000_BEEF, 5'd0, 1'b0,1'b0,1'b0,32'h0000_0000,1'b0,4'd1};
        vecs[8]  = '{1'b0,1'b0,1'b1,5'd2, 1'b1,1'b0,1'b0,32'h0000_0010, 5'd2, 1'b1,1'b0,1'b0,32'h0000_0010,1'b1,4'd1};
        vecs[9]  = '{1'b1,1'b1,1'b1,5'd11,1'b1,1'b0,1'b0,32'h0000_0099, 5'd0, 1'b0,1'b0,1'b0,32'h0000_0000,1'b0,4'd2};
        vecs[10] = '{1'b0,1'b0,1'b1,5'd31,1'b1,1'b1,1'b0,32'hFFFF_FFFF, 5'd31,1'b1,1'b1,1'b0,32'hFFFF_FFFF,1'b1,4'd2};

        for (int i = 0; i < 11; i++) begin
            hold_i  = vecs[i].hold;
            flush_i = vecs[i].flush;
            set_id(vecs[i].rd, vecs[i].rd ^ 5'd1, 1'b0, vecs[i].rd ^ 5'd2, 1'b0, vecs[i].wreg,
                   vecs[i].mem_rd, vecs[i].mem_wr, vecs[i].valid, vecs[i].op1);
            #1;
            check($sformatf("v%0d_stall", i), 32'(lu_stall_o), 32'd0);
            tick();
            check($sformatf("v%0d_rd", i),    32'(bus.exe_rd_o), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_ctl", i),   32'({bus.exe_wreg_o, bus.exe_mem_rd_o, bus.exe_mem_wr_o}),
                  32'({vecs[i].exp_wreg, vecs[i].exp_mem_rd, vecs[i].exp_mem_wr}));
            check($sformatf("v%0d_op1", i),   bus.exe_op1_o, vecs[i].exp_op1);
            check($sformatf("v%0d_valid", i), 32'(bus.exe_valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_cnt", i),   32'(bubble_cnt_o), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_op2", i),   bus.exe_op2_o, vecs[i].exp_valid ? ~vecs[i].exp_op1 : 32'd0);
            check($sformatf("v%0d_imm", i),   bus.exe_imm_o,
                  vecs[i].exp_valid ? {vecs[i].exp_op1[15:0], vecs[i].exp_op1[31:16]} : 32'd0);
            check($sformatf("v%0d_pc", i),    bus.exe_pc_o,
                  vecs[i].exp_valid ? (vecs[i].exp_op1 ^ 32'h0000_1000) : 32'd0);
            check($sformatf("v%0d_aluop", i), 32'(bus.exe_aluop_o),
                  vecs[i].exp_valid ? 32'(vecs[i].exp_rd ^ 5'h15) : 32'd0);
            check($sformatf("v%0d_rs", i),    32'({bus.exe_rs1_o, bus.exe_rs2_o}),
                  vecs[i].exp_valid ? 32'({vecs[i].exp_rd ^ 5'd1, vecs[i].exp_rd ^ 5'd2}) : 32'd0);
        end

        // Load-use: load rd=7 enters EX, then a consumer of x7 via rs2.
        hold_i  = 1'b0;
        flush_i = 1'b0;
        set_id(5'd7, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0700);
        tick();
        check("lu_load_rd", 32'(bus.exe_rd_o), 32'd7);
        set_id(5'd8, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_005A);
        #1;
        check("lu_stall_hit", 32'(lu_stall_o), 32'(LU_EN));
        tick();
        check("lu_bubble_rd",   32'(bus.exe_rd_o),   LU_EN ? 32'd0 : 32'd8);
        check("lu_bubble_wreg", 32'(bus.exe_wreg_o), LU_EN ? 32'd0 : 32'd1);
        check("lu_bubble_cnt",  32'(bubble_cnt_o),   LU_EN ? 32'd3 : 32'd2);
        check("lu_wait_stall",  32'(lu_stall_o), 32'd0);
        tick();
        check("lu_dep_rd",    32'(bus.exe_rd_o), 32'd8);
        check("lu_dep_op1",   bus.exe_op1_o, 32'h0000_005A);
        check("lu_dep_valid", 32'(bus.exe_valid_o), 32'd1);
        check("lu_dep_cnt",   32'(bubble_cnt_o), LU_EN ? 32'd3 : 32'd2);

        // Load to x0 never stalls.
        set_id(5'd0, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0001);
        tick();
        set_id(5'd10, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        #1;
        check("x0_stall", 32'(lu_stall_o), 32'd0);
        tick();
        check("x0_rd",  32'(bus.exe_rd_o), 32'd10);
        check("x0_cnt", 32'(bubble_cnt_o), LU_EN ? 32'd3 : 32'd2);

        // Hazard masked by hold, then by flush; the flush bubble is counted.
        set_id(5'd3, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0003);
        tick();
        set_id(5'd14, 5'd3, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0014);
        hold_i = 1'b1;
        #1;
        check("hold_stall", 32'(lu_stall_o), 32'd0);
        tick();
        check("hold_rd",  32'(bus.exe_rd_o), 32'd3);
        check("hold_cnt", 32'(bubble_cnt_o), LU_EN ? 32'd3 : 32'd2);
        hold_i  = 1'b0;
        flush_i = 1'b1;
        #1;
        check("flush_stall", 32'(lu_stall_o), 32'd0);
        tick();
        check("flush_valid", 32'(bus.exe_valid_o), 32'd0);
        check("flush_cnt",   32'(bubble_cnt_o), LU_EN ? 32'd4 : 32'd3);
        flush_i = 1'b0;

        // Saturation: 20 more bubbles must pin the 4-bit counter at 15.
        for (int i = 0; i < 20; i++) begin
            if (LU_EN) begin
                set_id(5'd7, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
                tick();
                set_id(5'd8, 5'd7, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
                tick();
                tick();
            end else begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
            end
            if (i == 10) check("sat_reach", 32'(bubble_cnt_o), LU_EN ? 32'd15 : 32'd14);
        end
        check("sat_cnt", 32'(bubble_cnt_o), 32'd15);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("sat_hold", 32'(bubble_cnt_o), 32'd15);

        // Reset clears a saturated counter.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst2_cnt", 32'(bubble_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
